// File: rtl/pico_bus_xbar_1n.sv
// Registered 1:N PicoRV32 native-bus decoder with decode-error and slave-timeout responses.
// Define PICO_BUS_ERR_STATUS_EN to add bus_err / err_addr / err_cause status outputs.
module pico_bus_xbar_1n #(
  parameter int                         NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {32'hC000_0000, 32'h8000_0000,
                                                          32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {4{32'hC000_0000}},
  parameter int                         TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         picom_valid,
  input  logic [31:0]                  picom_addr,
  input  logic [31:0]                  picom_wdata,
  input  logic [3:0]                   picom_wstrb,
  output logic                         picom_ready,
  output logic [31:0]                  picom_rdata,
  output logic [NUM_SLAVES-1:0]        picos_valid,
  output logic [31:0]                  picos_addr,
  output logic [31:0]                  picos_wdata,
  output logic [3:0]                   picos_wstrb,
  input  logic [NUM_SLAVES-1:0]        picos_ready,
  input  logic [NUM_SLAVES*32-1:0]     picos_rdata
`ifdef PICO_BUS_ERR_STATUS_EN
  ,
  output logic                         bus_err,
  output logic [31:0]                  err_addr,
  output logic [1:0]                   err_cause
`endif
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RESP} state_t;

  state_t                r_state;
  logic [SEL_W-1:0]      r_sel;
  logic [NUM_SLAVES-1:0] r_valid;
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;

  logic                  w_hit;
  logic [SEL_W-1:0]      w_sel;
  logic                  w_sel_rdy;
  logic                  w_tmo;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (~|((picom_addr ^ SLAVE_BASE[i*32 +: 32]) & SLAVE_MASK[i*32 +: 32])) begin
        w_hit = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
  end

  assign w_sel_rdy = picos_ready[r_sel];

  if (TIMEOUT_CYCLES > 0) begin : g_tmo
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst || r_state != S_ACTIVE) begin
        r_cnt <= '0;
      end else if (!w_sel_rdy && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_tmo
    assign w_tmo = 1'b0;
  end

`ifdef PICO_BUS_ERR_STATUS_EN
  logic        r_bus_err;
  logic [31:0] r_err_addr;
  logic [1:0]  r_err_cause;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_valid <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
`ifdef PICO_BUS_ERR_STATUS_EN
      r_bus_err   <= 1'b0;
      r_err_addr  <= '0;
      r_err_cause <= '0;
`endif
    end else begin
      r_ready <= 1'b0;
`ifdef PICO_BUS_ERR_STATUS_EN
      r_bus_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (picom_valid) begin
            if (w_hit) begin
              r_sel   <= w_sel;
              r_addr  <= picom_addr;
              r_wdata <= picom_wdata;
              r_wstrb <= picom_wstrb;
              r_valid <= NUM_SLAVES'(1) << w_sel;
              r_state <= S_ACTIVE;
            end else begin
              r_rdata <= ERR_RDATA;
              r_ready <= 1'b1;
              r_state <= S_RESP;
`ifdef PICO_BUS_ERR_STATUS_EN
              r_bus_err   <= 1'b1;
              r_err_addr  <= picom_addr;
              r_err_cause <= 2'b01;
`endif
            end
          end
        end
        S_ACTIVE: begin
          // Ready takes priority over a timeout landing on the same cycle.
          if (w_sel_rdy) begin
            r_rdata <= picos_rdata[r_sel*32 +: 32];
            r_valid <= '0;
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end else if (w_tmo) begin
            r_rdata <= ERR_RDATA;
            r_valid <= '0;
            r_ready <= 1'b1;
            r_state <= S_RESP;
`ifdef PICO_BUS_ERR_STATUS_EN
            r_bus_err   <= 1'b1;
            r_err_addr  <= r_addr;
            r_err_cause <= 2'b10;
`endif
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign picom_ready = r_ready;
  assign picom_rdata = r_rdata;
  assign picos_valid = r_valid;
  assign picos_addr  = r_addr;
  assign picos_wdata = r_wdata;
  assign picos_wstrb = r_wstrb;
`ifdef PICO_BUS_ERR_STATUS_EN
  assign bus_err   = r_bus_err;
  assign err_addr  = r_err_addr;
  assign err_cause = r_err_cause;
`endif

endmodule

// File: tb/tb_pico_bus_xbar_1n.sv
// Directed bench for pico_bus_xbar_1n: a 4-slave instance with an 8-cycle timeout
// and a 2-slave instance with a decode hole at 0x8000_0000.
module tb_pico_bus_xbar_1n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         m_vld, m_rdy;
  logic [31:0]  m_addr, m_wdata, m_rdata;
  logic [3:0]   m_wstrb;
  logic [3:0]   s_vld, s_rdy;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [127:0] s_rdata;

  logic         m2_vld, m2_rdy;
  logic [31:0]  m2_addr, m2_wdata, m2_rdata;
  logic [3:0]   m2_wstrb;
  logic [1:0]   s2_vld, s2_rdy;
  logic [31:0]  s2_addr, s2_wdata;
  logic [3:0]   s2_wstrb;
  logic [63:0]  s2_rdata;

`ifdef PICO_BUS_ERR_STATUS_EN
  logic         berr1, berr2;
  logic [31:0]  eaddr1, eaddr2;
  logic [1:0]   ecause1, ecause2;
`endif

  pico_bus_xbar_1n #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst),
    .picom_valid(m_vld), .picom_addr(m_addr), .picom_wdata(m_wdata), .picom_wstrb(m_wstrb),
    .picom_ready(m_rdy), .picom_rdata(m_rdata),
    .picos_valid(s_vld), .picos_addr(s_addr), .picos_wdata(s_wdata), .picos_wstrb(s_wstrb),
    .picos_ready(s_rdy), .picos_rdata(s_rdata)
`ifdef PICO_BUS_ERR_STATUS_EN
    , .bus_err(berr1), .err_addr(eaddr1), .err_cause(ecause1)
`endif
  );

  pico_bus_xbar_1n #(
    .NUM_SLAVES(2),
    .SLAVE_BASE({32'h4000_0000, 32'h0000_0000}),
    .SLAVE_MASK({2{32'hC000_0000}})
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .picom_valid(m2_vld), .picom_addr(m2_addr), .picom_wdata(m2_wdata), .picom_wstrb(m2_wstrb),
    .picom_ready(m2_rdy), .picom_rdata(m2_rdata),
    .picos_valid(s2_vld), .picos_addr(s2_addr), .picos_wdata(s2_wdata), .picos_wstrb(s2_wstrb),
    .picos_ready(s2_rdy), .picos_rdata(s2_rdata)
`ifdef PICO_BUS_ERR_STATUS_EN
    , .bus_err(berr2), .err_addr(eaddr2), .err_cause(ecause2)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          vcnt;
    bit          err;
    logic [1:0]  cause;
    logic [31:0] addr;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One transaction on the 4-slave instance; other slaves' ready is held high as noise.
  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input int sel, input int dly,
                     input logic [31:0] srd, input bit to);
    exp_t e;
    int   lat, vcnt;
    bit   got;
    e.err   = to;
    e.rdata = to ? 32'hDEAD_BEEF : srd;
    e.lat   = to ? 9 : dly + 2;
    e.vcnt  = to ? 8 : dly + 1;
    e.cause = 2'b10;
    e.addr  = a;
    exp_q.push_back(e);
    m_vld = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws;
    for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = (i == sel) ? srd : (32'hBAD0_0000 | i);
    s_rdy = '0;
    @(negedge clk);
    lat = 1;
    m_vld = 1'b0; m_addr = ~a; m_wdata = ~wd; m_wstrb = ~ws;
    check({tag, ".svld"},  s_vld,   32'(1 << sel));
    check({tag, ".saddr"}, s_addr,  a);
    check({tag, ".swdat"}, s_wdata, wd);
    check({tag, ".swstb"}, s_wstrb, ws);
    vcnt = 0;
    got  = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (s_vld[sel]) vcnt++;
      s_rdy = 4'(~(1 << sel)) | ((!to && k == dly) ? 4'(1 << sel) : 4'h0);
      @(negedge clk);
      lat++;
      s_rdy = '0;
      if (m_rdy) got = 1'b1;
    end
    check({tag, ".resp"}, got, 1);
    e = exp_q.pop_front();
    if (got) begin
      check({tag, ".rdata"}, m_rdata, e.rdata);
      check({tag, ".lat"},   lat,     e.lat);
      check({tag, ".vcnt"},  vcnt,    e.vcnt);
`ifdef PICO_BUS_ERR_STATUS_EN
      check({tag, ".berr"}, berr1, e.err);
      if (e.err) begin
        check({tag, ".ecause"}, ecause1, e.cause);
        check({tag, ".eaddr"},  eaddr1,  e.addr);
      end
`endif
      @(negedge clk);
      check({tag, ".rdy1cyc"}, m_rdy, 0);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    m_vld = 0;  m_addr = 0;  m_wdata = 0;  m_wstrb = 0;  s_rdy = 0;  s_rdata = '0;
    m2_vld = 0; m2_addr = 0; m2_wdata = 0; m2_wstrb = 0;
    s2_rdy = 2'b10; s2_rdata = {32'h2222_2222, 32'h1111_1111};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.svld",  s_vld,   0);
    check("rst.mrdy",  m_rdy,   0);
    check("rst.rdata", m_rdata, 0);
    check("rst.saddr", s_addr,  0);

    txn("rd_s1",    32'h4000_0010, 32'h0,          4'h0, 1, 3, 32'h1234_5678, 1'b0);
    txn("wr_s0",    32'h0000_0004, 32'hA5A5_A5A5,  4'hF, 0, 0, 32'h0BAD_F00D, 1'b0);
    txn("tmo_s2",   32'h8000_0020, 32'h0,          4'h0, 2, 0, 32'h5555_AAAA, 1'b1);
    txn("edge_s2",  32'h8000_0040, 32'h0,          4'h0, 2, 7, 32'h7777_0001, 1'b0);

    // Decode error on the 2-slave instance.
    e.rdata = 32'hDEAD_BEEF; e.lat = 1; e.vcnt = 0; e.err = 1'b1; e.cause = 2'b01;
    e.addr = 32'h8000_0000;
    exp_q.push_back(e);
    m2_vld = 1'b1; m2_addr = 32'h8000_0000;
    @(negedge clk);
    m2_vld = 1'b0;
    check("dec.svld", s2_vld, 0);
    check("dec.resp", m2_rdy, 1);
    e = exp_q.pop_front();
    if (m2_rdy) begin
      check("dec.rdata", m2_rdata, e.rdata);
`ifdef PICO_BUS_ERR_STATUS_EN
      check("dec.berr",   berr2,   e.err);
      check("dec.ecause", ecause2, e.cause);
      check("dec.eaddr",  eaddr2,  e.addr);
`endif
    end
    @(negedge clk);
    check("dec.rdy1cyc", m2_rdy, 0);

    // Normal access on the 2-slave instance; slave1 ready is held high.
    m2_vld = 1'b1; m2_addr = 32'h4000_0008;
    @(negedge clk);
    m2_vld = 1'b0;
    check("n2.svld", s2_vld, 32'h2);
    @(negedge clk);
    check("n2.resp",  m2_rdy,   1);
    check("n2.rdata", m2_rdata, 32'h2222_2222);
    @(negedge clk);

    // Reset in the middle of an ACTIVE transaction.
    m_vld = 1'b1; m_addr = 32'hC000_0000; m_wdata = 32'h1357_9BDF; m_wstrb = 4'h3; s_rdy = '0;
    @(negedge clk);
    m_vld = 1'b0;
    check("mid.svld", s_vld, 32'h8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_rdy = 4'h8;
    check("mid.rst.svld",   s_vld,    0);
    check("mid.rst.mrdy",   m_rdy,    0);
    check("mid.rst.rdata",  m_rdata,  0);
    check("mid.rst.saddr",  s_addr,   0);
    check("mid.rst.swdat",  s_wdata,  0);
    check("mid.rst.swstb",  s_wstrb,  0);
    check("mid.rst.m2rdat", m2_rdata, 0);
    @(negedge clk);
    s_rdy = '0;
    check("mid.stale.mrdy", m_rdy, 0);
    check("mid.stale.svld", s_vld, 0);

    txn("post_s3", 32'hC000_0100, 32'hCAFE_0001, 4'h1, 3, 1, 32'h3333_4444, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
